// File: rtl/alu_exec_unit.sv
// Execute-stage datapath: ALU control decode, 32-bit ALU, PC+4 / branch-target adders
// and a registered N/Z/V status register for the extended branch instructions.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  aluop,
  input  logic [3:0]  funct,
  input  logic [31:0] pc,
  input  logic [31:0] offset,
  input  logic        flags_we,
  output logic [2:0]  gout,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  output logic        n_flag,
  output logic        z_flag,
  output logic        v_flag
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  alu_op_e     w_op;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_ovf_add;
  logic        w_ovf_sub;
  logic        w_v_next;
  logic        r_n_flag;
  logic        r_z_flag;
  logic        r_v_flag;

  // aluop1 takes priority over aluop0; unknown R-type functs fall back to add.
  always_comb begin
    w_op = OP_ADD;
    if (aluop[1]) begin
      case (funct)
        4'b0000: w_op = OP_ADD;
        4'b0010: w_op = OP_SUB;
        4'b0100: w_op = OP_AND;
        4'b0101: w_op = OP_OR;
        4'b1010: w_op = OP_SLT;
        default: w_op = OP_ADD;
      endcase
    end else if (aluop[0]) begin
      w_op = OP_SUB;
    end
  end

  assign gout = w_op;

  assign w_sum     = a + b;
  assign w_diff    = a + ~b + 32'd1;
  assign w_ovf_add = (a[31] == b[31]) && (w_sum[31]  != a[31]);
  assign w_ovf_sub = (a[31] != b[31]) && (w_diff[31] != a[31]);

  always_comb begin
    result   = '0;
    w_v_next = 1'b0;
    case (w_op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result   = w_sum;
        w_v_next = w_ovf_add;
      end
      OP_SUB: begin
        result   = w_diff;
        w_v_next = w_ovf_sub;
      end
      // Signed compare corrected for subtraction overflow.
      OP_SLT: result = {31'd0, w_diff[31] ^ w_ovf_sub};
      default: result = '0;
    endcase
  end

  assign zero          = ~|result;
  assign pc_plus4      = pc + 32'h4;
  assign branch_target = pc_plus4 + (offset << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n_flag <= 1'b0;
      r_z_flag <= 1'b0;
      r_v_flag <= 1'b0;
    end else if (flags_we) begin
      r_n_flag <= result[31];
      r_z_flag <= zero;
      r_v_flag <= w_v_next;
    end
  end

  assign n_flag = r_n_flag;
  assign z_flag = r_z_flag;
  assign v_flag = r_v_flag;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, pc, offset;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic        flags_we;
  logic [2:0]  gout;
  logic [31:0] result, pc_plus4, branch_target;
  logic        zero, n_flag, z_flag, v_flag;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .aluop(aluop), .funct(funct),
    .pc(pc), .offset(offset), .flags_we(flags_we), .gout(gout),
    .result(result), .zero(zero), .pc_plus4(pc_plus4),
    .branch_target(branch_target), .n_flag(n_flag), .z_flag(z_flag),
    .v_flag(v_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic n, input logic z, input logic v);
    chk(tag, {29'd0, n_flag, z_flag, v_flag}, {29'd0, n, z, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with flags_we high: reset must win even though n/v would be set.
    rst = 1'b1; flags_we = 1'b1; aluop = 2'b00; funct = 4'b0000;
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; pc = 32'h0; offset = 32'h0;
    tick();
    chk_flags("reset_flags", 1'b0, 1'b0, 1'b0);
    chk("reset_result_comb", result, 32'h8000_0000);
    rst = 1'b0; flags_we = 1'b0;

    aluop = 2'b00; #1 chk("dec_00", {29'd0, gout}, 32'd2);
    aluop = 2'b01; #1 chk("dec_01", {29'd0, gout}, 32'd6);
    aluop = 2'b10;
    funct = 4'b0000; #1 chk("dec_r_add", {29'd0, gout}, 32'd2);
    funct = 4'b0010; #1 chk("dec_r_sub", {29'd0, gout}, 32'd6);
    funct = 4'b0100; #1 chk("dec_r_and", {29'd0, gout}, 32'd0);
    funct = 4'b0101; #1 chk("dec_r_or",  {29'd0, gout}, 32'd1);
    funct = 4'b1010; #1 chk("dec_r_slt", {29'd0, gout}, 32'd7);
    funct = 4'b1111; #1 chk("dec_r_dflt", {29'd0, gout}, 32'd2);
    aluop = 2'b11; funct = 4'b0100; #1 chk("dec_11_prio", {29'd0, gout}, 32'd0);

    // add overflow
    aluop = 2'b00; a = 32'h7FFF_FFFF; b = 32'h1; flags_we = 1'b1; #1;
    chk("add_ovf_result", result, 32'h8000_0000);
    chk("add_ovf_zero", {31'd0, zero}, 32'd0);
    tick();
    chk_flags("add_ovf_flags", 1'b1, 1'b0, 1'b1);

    // sub to zero
    aluop = 2'b01; a = 32'd5; b = 32'd5; #1;
    chk("sub_zero_result", result, 32'h0);
    chk("sub_zero_zero", {31'd0, zero}, 32'd1);
    tick();
    chk_flags("sub_zero_flags", 1'b0, 1'b1, 1'b0);
    flags_we = 1'b0;

    aluop = 2'b10; funct = 4'b1010;
    a = 32'hFFFF_FFFF; b = 32'h1;          #1 chk("slt_neg1_lt_1", result, 32'd1);
    a = 32'h8000_0000; b = 32'h7FFF_FFFF;  #1 chk("slt_min_lt_max", result, 32'd1);
    a = 32'h7FFF_FFFF; b = 32'h8000_0000;  #1 chk("slt_max_lt_min", result, 32'd0);

    a = 32'hF0F0_F0F0; b = 32'h0FF0_0FF0;
    funct = 4'b0100; #1 chk("and_result", result, 32'h00F0_00F0);
    funct = 4'b0101; flags_we = 1'b1; #1 chk("or_result", result, 32'hFFF0_FFF0);
    tick();
    chk_flags("or_flags", 1'b1, 1'b0, 1'b0);

    // sub overflow, then hold for 3 cycles with changing operands
    aluop = 2'b01; a = 32'h8000_0000; b = 32'h1; #1;
    chk("sub_ovf_result", result, 32'h7FFF_FFFF);
    tick();
    chk_flags("sub_ovf_flags", 1'b0, 1'b0, 1'b1);
    flags_we = 1'b0;
    aluop = 2'b00; a = 32'h0; b = 32'h0; tick();
    chk_flags("hold_1", 1'b0, 1'b0, 1'b1);
    a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; tick();
    chk_flags("hold_2", 1'b0, 1'b0, 1'b1);
    aluop = 2'b10; funct = 4'b0101; a = 32'h8000_0000; b = 32'h0; tick();
    chk_flags("hold_3", 1'b0, 1'b0, 1'b1);

    pc = 32'h0000_0010; offset = 32'hFFFF_FFFE; #1;
    chk("pc_plus4", pc_plus4, 32'h0000_0014);
    chk("branch_back", branch_target, 32'h0000_000C);
    pc = 32'hFFFF_FFFC; offset = 32'h1; #1;
    chk("pc_plus4_wrap", pc_plus4, 32'h0);
    chk("branch_wrap", branch_target, 32'h4);

    // reset again after flags were set
    rst = 1'b1; flags_we = 1'b1; tick();
    chk_flags("reset_again", 1'b0, 1'b0, 1'b0);
    rst = 1'b0; flags_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage datapath block for the single-cycle MIPS processor. It decodes the ALU operation from the two main-control ALUOp bits and the instruction funct field, and performs the 32-bit ALU operation. It also computes PC+4 and the branch target, and holds a registered N/Z/V status register for the extended branch instructions. Everything is combinational except the status register.

## Interface
- No parameters; datapath width is fixed at 32 bits.
- clk  input  1  system clock; status register updates on rising edge
- rst  input  1  synchronous, active-high reset; clears status register
- a  input  32  ALU operand A (register read data 1)
- b  input  32  ALU operand B (output of the ALUSrc mux)
- aluop  input  2  {aluop1, aluop0} from main control
- funct  input  4  instruction bits [3:0]
- pc  input  32  current program counter
- offset  input  32  sign-extended immediate, not yet shifted
- flags_we  input  1  latch N/Z/V this cycle
- gout  output  3  decoded ALU operation code
- result  output  32  ALU result
- zero  output  1  combinational, 1 when result == 0
- pc_plus4  output  32  pc + 4
- branch_target  output  32  pc_plus4 + (offset << 2)
- n_flag, z_flag, v_flag  output  1 each  registered status bits

## Operation
- **ALU control decode (gout)**
  - aluop=00 -> 010 (add: lw/sw/addi).
  - aluop=01 -> 110 (sub: beq).
  - aluop=1x is R-type and is decoded from funct:
    - 0000 -> 010 (add)
    - 0010 -> 110 (sub)
    - 0100 -> 000 (and)
    - 0101 -> 001 (or)
    - 1010 -> 111 (slt)
    - any other funct -> 010 (add).
  - aluop1 has priority over aluop0.
- **ALU, selected by gout**
  - 000: a & b
  - 001: a | b
  - 010: a + b, modulo 2^32
  - 110: a - b, computed as a + ~b + 1, modulo 2^32
  - 111: result = 32'd1 if a < b as signed two's complement (overflow-corrected: less = diff[31] XOR ovf_sub), else 32'd0
  - 011, 100, 101: result = 0
- zero = ~|result.
- **Overflow (combinational v_next)**
  - add: a[31]==b[31] and result[31]!=a[31].
  - sub: a[31]!=b[31] and result[31]!=a[31].
  - all other operations: 0.
- n_next = result[31]; z_next = zero.
- **Adders:** pc_plus4 = pc + 32'h4; branch_target = pc_plus4 + {offset[29:0], 2'b00}. Both wrap modulo 2^32 with no carry out.

## Timing
- gout, result, zero, pc_plus4 and branch_target are purely combinational. They have zero-cycle latency and are not affected by rst.
- **Status register, at posedge clk:**
  - rst=1: n_flag, z_flag and v_flag are all cleared to 0.
  - else if flags_we=1: flags load n_next, z_next, v_next.
  - else: flags hold.
- rst has priority over flags_we when both are asserted in the same cycle.
- Flags loaded at edge k are visible from edge k until the next load. A consumer reading them in cycle k+1 sees the result of the cycle-k operation.
- Reset value of every registered output is 0.
- Flags are not initialised without rst; the bench must apply rst for at least one cycle before checking them.

## Test plan
- Reset: assert rst for 1 cycle with flags_we=1 -> n_flag=z_flag=v_flag=0 after the edge; result still tracks a/b combinationally.
- Decode sweep:
  - aluop=00 -> gout=010; aluop=01 -> gout=110.
  - aluop=10 with funct 0000/0010/0100/0101/1010/1111 -> gout 010/110/000/001/111/010.
  - aluop=11, funct=0100 -> gout=000.
- Arithmetic and flags:
  - add 7FFFFFFF+1 -> result 80000000, zero=0; with flags_we=1, next edge n=1, v=1, z=0.
  - sub 5-5 -> result 0, zero=1; latched z=1, v=0.
- Signed slt:
  - a=FFFFFFFF, b=1 -> result 1.
  - a=80000000, b=7FFFFFFF -> result 1 (overflow-corrected).
  - a=7FFFFFFF, b=80000000 -> result 0.
- Logic: a=F0F0F0F0, b=0FF00FF0 -> and = 00F000F0, or = FFF0FFF0, v=0.
- Adders and hold:
  - pc=00000010, offset=FFFFFFFE -> pc_plus4=00000014, branch_target=0000000C.
  - pc=FFFFFFFC -> pc_plus4=0 (wrap).
  - flags_we=0 for 3 cycles with changing operands -> flags hold their last values.
